// File: rtl/interval_timer.sv
// Programmable interval timer: counts a selected interval in prescaled ticks
// and pulses expired once the interval has elapsed.
module interval_timer #(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [3:0]  DEF_BASE = 4'd6,
  parameter logic [3:0]  DEF_EXT  = 4'd3,
  parameter logic [3:0]  DEF_YEL  = 4'd2
) (
  input  logic       clk,
  input  logic       g_reset,
  input  logic       start_timer,
  input  logic [1:0] interval,
  input  logic       prog_sync,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  output logic       expired,
  output logic       busy,
  output logic [3:0] remaining
);

  localparam int unsigned TW = 4;
  localparam int unsigned PW = 8;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state, state_n;
  logic [TW-1:0] base_reg, ext_reg, yel_reg;
  logic [TW-1:0] count;
  logic [PW-1:0] presc;
  logic          start_d;
  logic          start_ev;
  logic          tick_end;
  logic [TW-1:0] sel_val;
  logic          expired_n, busy_n;
  logic [TW-1:0] remaining_n;

  assign start_ev = start_timer & ~start_d;
  assign tick_end = (presc == PRESC_MAX);

  // Selection reads the registers before any same-cycle write lands.
  always_comb begin
    sel_val = '0;
    case (interval)
      2'b00:   sel_val = base_reg;
      2'b01:   sel_val = ext_reg;
      2'b10:   sel_val = yel_reg;
      default: sel_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge g_reset) begin
    if (g_reset) begin
      base_reg <= DEF_BASE;
      ext_reg  <= DEF_EXT;
      yel_reg  <= DEF_YEL;
    end else if (prog_sync) begin
      case (time_param_sel)
        2'b00:   base_reg <= time_value;
        2'b01:   ext_reg  <= time_value;
        2'b10:   yel_reg  <= time_value;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge g_reset) begin
    if (g_reset) state <= IDLE;
    else         state <= state_n;
  end

  // A start event overrides whatever the current state would do.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = IDLE;
      RUN:     if (tick_end && count == TW'(1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (start_ev) state_n = (sel_val == '0) ? DONE : RUN;
  end

  always_comb begin
    expired_n   = (state == DONE);
    busy_n      = (state != IDLE);
    remaining_n = (state == RUN) ? count : '0;
  end

  always_ff @(posedge clk or posedge g_reset) begin
    if (g_reset) begin
      expired   <= 1'b0;
      busy      <= 1'b0;
      remaining <= '0;
    end else begin
      expired   <= expired_n;
      busy      <= busy_n;
      remaining <= remaining_n;
    end
  end

  always_ff @(posedge clk or posedge g_reset) begin
    if (g_reset) begin
      start_d <= 1'b0;
      count   <= '0;
      presc   <= '0;
    end else begin
      start_d <= start_timer;
      if (start_ev) begin
        count <= sel_val;
        presc <= '0;
      end else if (state == RUN) begin
        if (tick_end) begin
          presc <= '0;
          count <= count - TW'(1);
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_interval_timer.sv
// Scoreboard bench for interval_timer: stimulus queues timestamped expectations,
// a negedge monitor compares expired pulses and busy/remaining snapshots.
module tb_interval_timer;

  logic       clk = 1'b0;
  logic       g_reset;
  logic       start_timer;
  logic [1:0] interval;
  logic       prog_sync;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       expired;
  logic       busy;
  logic [3:0] remaining;

  interval_timer dut (
    .clk            (clk),
    .g_reset        (g_reset),
    .start_timer    (start_timer),
    .interval       (interval),
    .prog_sync      (prog_sync),
    .time_param_sel (time_param_sel),
    .time_value     (time_value),
    .expired        (expired),
    .busy           (busy),
    .remaining      (remaining)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       busy;
    logic [3:0] rem;
  } chk_t;

  int   cyc = 0;
  int   exp_q[$];
  chk_t chk_q[$];
  bit   done = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic want;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sole owner of the comparison counters.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0] < cyc) begin
      n_cmp++; n_err++;
      $display("FAIL expired_missing: expected pulse at cycle %0d was absent", exp_q[0]);
      void'(exp_q.pop_front());
    end
    want = (exp_q.size() > 0 && exp_q[0] == cyc);
    if (want || expired) begin
      n_cmp++;
      if (expired !== want) begin
        n_err++;
        $display("FAIL expired_pulse: cycle %0d expired=%b required=%b", cyc, expired, want);
      end
      if (want) void'(exp_q.pop_front());
    end
    while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
      n_cmp++;
      if (chk_q[0].cyc != cyc || busy !== chk_q[0].busy || remaining !== chk_q[0].rem) begin
        n_err++;
        $display("FAIL outputs: cycle %0d (due %0d) busy=%b rem=%0d required busy=%b rem=%0d",
                 cyc, chk_q[0].cyc, busy, remaining, chk_q[0].busy, chk_q[0].rem);
      end
      void'(chk_q.pop_front());
    end
    if (done) begin
      n_cmp++;
      if (exp_q.size() != 0 || chk_q.size() != 0) begin
        n_err++;
        $display("FAIL leftover: %0d pulses and %0d snapshots outstanding, required 0",
                 exp_q.size(), chk_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_chk(input int c, input logic b, input logic [3:0] r);
    chk_t e;
    e.cyc = c; e.busy = b; e.rem = r;
    chk_q.push_back(e);
  endtask

  // Raise start for one edge; e returns the start-event edge number.
  task automatic do_start(input logic [1:0] iv, output int e);
    interval    = iv;
    start_timer = 1'b1;
    e = cyc + 1;
    tick(1);
    start_timer = 1'b0;
  endtask

  task automatic prog(input logic [1:0] sel, input logic [3:0] val);
    prog_sync = 1'b1; time_param_sel = sel; time_value = val;
    tick(1);
    prog_sync = 1'b0;
  endtask

  initial begin
    int e, e1;
    g_reset = 1'b1; start_timer = 1'b0; interval = 2'b00;
    prog_sync = 1'b0; time_param_sel = 2'b11; time_value = 4'd0;
    tick(2);
    push_chk(cyc, 1'b0, 4'd0);
    tick(1);
    g_reset = 1'b0;
    tick(2);

    // Base interval: 6 ticks of 4 cycles
    do_start(2'b00, e);
    exp_q.push_back(e + 25);
    for (int k = 1; k <= 8; k++) push_chk(e + k, 1'b1, (k <= 4) ? 4'd6 : 4'd5);
    push_chk(e + 24, 1'b1, 4'd1);
    push_chk(e + 25, 1'b1, 4'd0);
    push_chk(e + 26, 1'b0, 4'd0);
    tick(30);

    // Zero interval
    do_start(2'b11, e);
    exp_q.push_back(e + 1);
    push_chk(e + 1, 1'b1, 4'd0);
    push_chk(e + 2, 1'b0, 4'd0);
    tick(5);

    // Programmed yellow = 5
    prog(2'b10, 4'd5);
    do_start(2'b10, e);
    exp_q.push_back(e + 21);
    tick(25);
    prog(2'b11, 4'd1);
    // Write to yellow in the start cycle: start still sees 5
    prog_sync = 1'b1; time_param_sel = 2'b10; time_value = 4'd1;
    do_start(2'b10, e);
    prog_sync = 1'b0;
    exp_q.push_back(e + 21);
    tick(25);
    do_start(2'b10, e);
    exp_q.push_back(e + 5);
    tick(8);

    // Restart mid-run with ext interval
    do_start(2'b00, e1);
    tick(e1 + 9 - cyc);
    do_start(2'b01, e);
    exp_q.push_back(e + 13);
    push_chk(e + 1, 1'b1, 4'd3);
    tick(20);

    // Reset mid-run aborts, then base register reads back default
    prog(2'b00, 4'd2);
    do_start(2'b00, e);
    tick(e + 8 - cyc);
    g_reset = 1'b1;
    push_chk(cyc, 1'b0, 4'd0);
    tick(2);
    g_reset = 1'b0;
    tick(30);
    do_start(2'b00, e);
    exp_q.push_back(e + 25);
    tick(30);

    // Start already high at reset release is a start event
    g_reset = 1'b1; start_timer = 1'b1; interval = 2'b11;
    tick(1);
    g_reset = 1'b0;
    e = cyc + 1;
    exp_q.push_back(e + 1);
    tick(1);
    start_timer = 1'b0;
    tick(4);

    // Held start: one pulse only
    interval = 2'b10; start_timer = 1'b1;
    e = cyc + 1;
    exp_q.push_back(e + 9);
    tick(60);
    start_timer = 1'b0;
    tick(5);

    done = 1'b1;
  end

endmodule
